// File: rtl/handshake_pkg.sv
// handshake_pkg: shared types and helpers for the handshake sink.
package handshake_pkg;

    typedef enum logic {
        RESET_WAIT = 1'b0,
        ACTIVE     = 1'b1
    } sink_state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/handshake_fifo_core.sv
// handshake_fifo_core: first-word-fall-through FIFO storage with wrapping pointers and occupancy.
module handshake_fifo_core #(
    parameter  int DATA_BITS = 8,
    parameter  int DEPTH     = 4,
    localparam int AW        = $clog2(DEPTH),
    localparam int LW        = AW + 1
) (
    input  logic                 clk,
    input  logic                 arstn,
    input  logic                 push,
    input  logic                 pop,
    input  logic [DATA_BITS-1:0] wdata,
    output logic [DATA_BITS-1:0] rdata,
    output logic [LW-1:0]        level,
    output logic                 empty,
    output logic                 full
);

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [AW-1:0]        wptr;
    logic [AW-1:0]        rptr;

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            level <= level + LW'(push) - LW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wdata;
    end

    assign rdata = mem[rptr];
    assign empty = (level == '0);
    assign full  = (level == LW'(DEPTH));

endmodule

// File: rtl/handshake_sink.sv
// handshake_sink: valid/ready sink buffering beats for a local FWFT consumer.
// Define HANDSHAKE_SINK_STATS_EN to add the saturating beat_count output.
module handshake_sink
    import handshake_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int DEPTH        = 4,
    parameter int ALWAYS_READY = 0
) (
    input  logic                   clk,
    input  logic                   arstn,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [DATA_BITS-1:0]   s_data,
    input  logic                   rd_en,
    output logic                   rd_valid,
    output logic [DATA_BITS-1:0]   rd_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow
`ifdef HANDSHAKE_SINK_STATS_EN
    ,
    output logic [31:0]            beat_count
`endif
);

    sink_state_t state;
    logic        empty;
    logic        full;
    logic        push;
    logic        pop;
    logic        drop;

    assign s_ready  = (state == ACTIVE) && (ALWAYS_READY != 0 || !full);
    assign rd_valid = !empty;
    assign pop      = rd_en && rd_valid;
    // When always ready, a full buffer only takes a beat if the head leaves on the same edge.
    assign push     = s_valid && s_ready && (!full || pop);
    assign drop     = (ALWAYS_READY != 0) && s_valid && s_ready && full && !pop;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state    <= RESET_WAIT;
            overflow <= 1'b0;
        end else begin
            state    <= ACTIVE;
            overflow <= overflow | drop;
        end
    end

`ifdef HANDSHAKE_SINK_STATS_EN
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) beat_count <= '0;
        else if (push) beat_count <= sat_inc(beat_count);
    end
`endif

    handshake_fifo_core #(
        .DATA_BITS(DATA_BITS),
        .DEPTH    (DEPTH)
    ) u_core (
        .clk  (clk),
        .arstn(arstn),
        .push (push),
        .pop  (pop),
        .wdata(s_data),
        .rdata(rd_data),
        .level(level),
        .empty(empty),
        .full (full)
    );

endmodule

// File: tb/tb_handshake_sink.sv
// tb_handshake_sink: scoreboard bench driving both ready policies side by side.
module tb_handshake_sink;
    localparam int DW = 8;
    localparam int D  = 4;

    typedef logic [DW-1:0] dq_t[$];

    logic          clk   = 1'b1;
    logic          arstn = 1'b1;
    logic          s_valid [2];
    logic          s_ready [2];
    logic [DW-1:0] s_data [2];
    logic          rd_en [2];
    logic          rd_valid [2];
    logic [DW-1:0] rd_data [2];
    logic [2:0]    level [2];
    logic          overflow [2];
`ifdef HANDSHAKE_SINK_STATS_EN
    logic [31:0]   beat_count [2];
`endif

    dq_t sb [2];
    int  cnt [2];
    int  beats [2];
    bit  act [2];
    bit  ov [2];
    bit  m_pop;
    bit  m_acc;
    int  compared   = 0;
    int  mismatched = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : lane
        handshake_sink #(.DATA_BITS(DW), .DEPTH(D), .ALWAYS_READY(g)) dut (
            .clk     (clk),
            .arstn   (arstn),
            .s_valid (s_valid[g]),
            .s_ready (s_ready[g]),
            .s_data  (s_data[g]),
            .rd_en   (rd_en[g]),
            .rd_valid(rd_valid[g]),
            .rd_data (rd_data[g]),
            .level   (level[g]),
            .overflow(overflow[g])
`ifdef HANDSHAKE_SINK_STATS_EN
            ,
            .beat_count(beat_count[g])
`endif
        );
    end

    // Reference: a queue of accepted beats per lane; lane 1 is the always-ready policy.
    always @(posedge clk or negedge arstn) begin
        for (int g = 0; g < 2; g++) begin
            if (!arstn) begin
                sb[g].delete();
                cnt[g]   = 0;
                beats[g] = 0;
                act[g]   = 1'b0;
                ov[g]    = 1'b0;
            end else if (!act[g]) begin
                act[g] = 1'b1;
            end else begin
                m_pop = rd_en[g] && (cnt[g] > 0);
                m_acc = s_valid[g] && (cnt[g] < D || (g == 1 && m_pop));
                if (g == 1 && s_valid[g] && cnt[g] == D && !m_pop) ov[g] = 1'b1;
                if (m_pop) void'(sb[g].pop_front());
                if (m_acc) begin
                    sb[g].push_back(s_data[g]);
                    if (beats[g] != -1) beats[g]++;
                end
                cnt[g] = cnt[g] + int'(m_acc) - int'(m_pop);
            end
        end
    end

    task automatic chk(input string name, input int g, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s lane%0d got=%0h expected=%0h at %0t", name, g, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            chk("level", g, 32'(level[g]), cnt[g]);
            chk("rd_valid", g, 32'(rd_valid[g]), 32'(cnt[g] > 0));
            chk("s_ready", g, 32'(s_ready[g]), 32'(act[g] && (g == 1 || cnt[g] < D)));
            chk("overflow", g, 32'(overflow[g]), 32'(ov[g]));
`ifdef HANDSHAKE_SINK_STATS_EN
            chk("beat_count", g, beat_count[g], beats[g]);
`endif
            if (cnt[g] > 0) chk("rd_data", g, 32'(rd_data[g]), 32'(sb[g][0]));
        end
    end

    task automatic step(input logic v0, input logic [DW-1:0] d0, input logic r0,
                        input logic v1, input logic [DW-1:0] d1, input logic r1);
        s_valid[0] = v0;
        s_data[0]  = d0;
        rd_en[0]   = r0;
        s_valid[1] = v1;
        s_data[1]  = d1;
        rd_en[1]   = r1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rp;
        s_valid = '{1'b1, 1'b1};
        s_data  = '{8'hEE, 8'hEE};
        rd_en   = '{1'b0, 1'b0};
        #1 arstn = 1'b0;
        #104 arstn = 1'b1;
        @(posedge clk);
        #1;
        step(1, 8'hA5, 0, 1, 8'hA5, 0);
        step(1, 8'hC4, 0, 1, 8'hC4, 0);
        step(0, 8'h00, 0, 0, 8'h00, 0);
        repeat (3) step(0, 8'h00, 1, 0, 8'h00, 1);
        for (int k = 1; k <= 4; k++) step(1, 8'(k), 0, 1, 8'(k), 0);
        step(1, 8'h05, 0, 1, 8'h55, 0);
        step(1, 8'h05, 0, 0, 8'h00, 0);
        step(1, 8'h05, 1, 1, 8'h66, 1);
        step(1, 8'h05, 0, 0, 8'h00, 1);
        repeat (5) step(0, 8'h00, 1, 0, 8'h00, 1);
        for (int k = 0; k < 3; k++) step(1, 8'(8'h10 + k), 0, 1, 8'(8'h20 + k), 0);
        s_valid = '{1'b1, 1'b1};
        s_data  = '{8'hEE, 8'hEE};
        #2 arstn = 1'b0;
        @(negedge clk);
        #2 arstn = 1'b1;
        @(posedge clk);
        #1;
        step(1, 8'hA5, 0, 1, 8'hA5, 0);
        step(0, 8'h00, 1, 0, 8'h00, 1);
        for (int i = 0; i < 3000; i++) begin
            rp = (i / 200) % 3 == 0 ? 20 : (i / 200) % 3 == 1 ? 50 : 90;
            step($urandom_range(0, 99) < 70, 8'($urandom), $urandom_range(0, 99) < rp,
                 $urandom_range(0, 99) < 70, 8'($urandom), $urandom_range(0, 99) < rp);
        end
        repeat (8) step(0, 8'h00, 1, 0, 8'h00, 1);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/handshake_sink.md
HANDSHAKE_SINK -- requirements
Module: handshake_sink

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, width of s_data/rd_data.
REQ-002 SHALL have parameter DEPTH, default 4, buffer entries; power of two, >=2.
REQ-003 SHALL have parameter ALWAYS_READY, default 0; 1 = s_ready held high while ACTIVE, excess beats dropped.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port arstn  input  1  reset; one clock, asynchronous active-low reset.
REQ-006 SHALL have port s_valid  input  1  upstream beat present.
REQ-007 SHALL have port s_ready  output  1  sink can accept beat.
REQ-008 SHALL have port s_data  input  DATA_BITS  upstream beat payload.
REQ-009 SHALL have port rd_en  input  1  local consumer pops head entry.
REQ-010 SHALL have port rd_valid  output  1  buffer non-empty.
REQ-011 SHALL have port rd_data  output  DATA_BITS  head entry, first-word-fall-through.
REQ-012 SHALL have port level  output  $clog2(DEPTH)+1  current occupancy.
REQ-013 SHALL have port overflow  output  1  sticky, beat dropped (ALWAYS_READY=1 only).

Function
REQ-014 SHALL implement FSM states RESET_WAIT and ACTIVE; RESET_WAIT -> ACTIVE on first clk edge with arstn high; no other transition except reset.
REQ-015 SHALL accept a beat (push) on a clk edge where s_valid && s_ready, writing s_data at the tail.
REQ-016 SHALL drive s_ready = ACTIVE && (level < DEPTH) when ALWAYS_READY=0; s_ready never depends on s_valid.
REQ-017 SHALL drive s_ready = ACTIVE when ALWAYS_READY=1.
REQ-018 SHALL pop the head on a clk edge where rd_en && rd_valid; rd_en while empty is ignored, no state change.
REQ-019 SHALL present rd_data combinationally from head with zero-cycle latency; a pushed beat is visible on rd_data the cycle after its push edge.
REQ-020 SHALL update level by +1 push only, -1 pop only, unchanged on simultaneous push and pop.
REQ-021 SHALL, with ALWAYS_READY=0 and full, hold s_ready low; a same-cycle pop frees space for the next cycle only.
REQ-022 SHALL, with ALWAYS_READY=1 and full, accept a push coinciding with a pop; a push without pop is dropped, contents unchanged, overflow set.
REQ-023 SHALL wrap read/write pointers modulo DEPTH; data order strictly FIFO.
REQ-024 SHALL keep overflow at 0 permanently when ALWAYS_READY=0.

Reset
REQ-025 SHALL, while arstn low: state RESET_WAIT, pointers 0, level 0, rd_valid 0, s_ready 0, overflow 0; rd_data undefined-but-stable.
REQ-026 SHALL discard all buffered beats on reset assertion mid-operation; no partial pop/push completes on that edge.
REQ-027 SHALL ignore s_valid until ACTIVE.

Configuration
REQ-028 SHALL, with macro HANDSHAKE_SINK_STATS_EN defined, add output beat_count (32 bits): counts accepted pushes, saturates at 32'hFFFF_FFFF, reset to 0.
REQ-029 SHALL, without HANDSHAKE_SINK_STATS_EN, omit beat_count port and counter entirely; other behaviour identical.

Structure
REQ-030 SHALL place the sink FSM state enum typedef in shared package handshake_pkg.
REQ-031 SHALL implement storage array and pointers in one sub-module, handshake_fifo_core; FSM, ready policy, overflow and stats remain in handshake_sink.

Verification
REQ-032 SHALL verify: reset released at 105 ns -> s_ready 0 until first posedge after release, then 1; level 0.
REQ-033 SHALL verify: push 8'hA5 then 8'hC4, rd_en low -> level 2, rd_data 8'hA5; pop once -> rd_data 8'hC4, level 1.
REQ-034 SHALL verify: ALWAYS_READY=0, DEPTH=4, five back-to-back beats 1..5 -> s_ready low after 4th, 5th held until pop, pops return 1,2,3,4,5.
REQ-035 SHALL verify: ALWAYS_READY=1, full with 1..4, push 8'h55 without pop -> overflow 1, pops return 1..4; push with pop when full -> accepted, overflow unchanged.
REQ-036 SHALL verify: 3 beats buffered, arstn pulsed low mid-stream -> level 0, rd_valid 0 immediately; 8'hA5 pushed after -> first pop returns 8'hA5.
REQ-037 SHALL verify: HANDSHAKE_SINK_STATS_EN defined, 10 accepted beats with 2 dropped (ALWAYS_READY=1) -> beat_count 10.
